pc_call_stack: RTL and testbench
================================

// Module: pc_call_stack
// PURPOSE
//   Parametrised program counter with an integrated return-address stack (RAS).
//   Successor to the 16-bit reset/load/inc counter. Adds stall, call/return, configurable width and step.
//   Feeds instruction-memory address in the CPU fetch stage; load/call/ret driven by decode/jump logic.
// PARAMETERS
//   WIDTH         16   PC and stack entry width in bits
//   DEPTH         8    RAS entries (power of 2, >=2)
//   RESET_VECTOR  0    value of out after reset (WIDTH bits)
//   INC_STEP      1    amount added on inc and for call return address
// PORTS
//   clk          in   1                   rising-edge clock
//   reset_n      in   1                   async active-low reset
//   in           in   WIDTH               jump/call target
//   load         in   1                   out <= in
//   inc          in   1                   out <= out + INC_STEP
//   stall        in   1                   freeze PC and stack
//   call         in   1                   push out+INC_STEP, out <= in
//   ret          in   1                   pop, out <= popped address
//   out          out  WIDTH               current PC
//   depth_cnt    out  $clog2(DEPTH)+1     valid stack entries
//   stack_full   out  1                   depth_cnt == DEPTH
//   stack_empty  out  1                   depth_cnt == 0
//   stack_ovf    out  1                   sticky overflow flag (macro-gated)
//   stack_unf    out  1                   sticky underflow flag (macro-gated)
// BEHAVIOUR
//   - reset_n low (async, any time): out=RESET_VECTOR, depth_cnt=0, ovf=unf=0; stack contents don't-care.
//   - All updates on rising clk; out is registered, new value visible 1 cycle after the command edge.
//   - Priority per edge: stall > ret > call > load > inc > hold. Only the winner acts.
//   - stall=1: out, stack and flags unchanged regardless of other inputs.
//   - ret, not empty: out <= stack[top]; depth_cnt-1.
//   - ret, empty: out holds; depth_cnt stays 0; unf set.
//   - call, not full: stack[depth_cnt] <= out+INC_STEP; out <= in; depth_cnt+1.
//   - call, full: out <= in (jump still taken); push dropped; depth_cnt stays DEPTH; ovf set.
//   - load: out <= in. inc: out <= out+INC_STEP. None asserted: hold.
//   - Arithmetic is modulo 2^WIDTH: 16'hFFFF + 1 -> 16'h0000, no flag.
//   - Signed-looking input values (e.g. -32123) are treated as raw bits (16'h8285).
//   - stack_full/stack_empty are combinational from depth_cnt.
//   - Flags clear only on reset.
// CONFIGURATION
//   PC_STACK_ERR_EN defined:
//     stack_ovf/stack_unf are registered sticky flags as above.
//   PC_STACK_ERR_EN undefined:
//     stack_ovf=stack_unf=0 constant; flag registers not built.
//     Overflow and underflow data behaviour unchanged (push dropped, ret holds).
// TESTING
//   1 Reset/inc: reset_n=0, then inc=1 x3 cycles -> out 0,1,2,3.
//     Assert reset_n=0 mid-cycle -> out=0 immediately, without waiting for clk.
//   2 Load/wrap: load in=16'hFFFF, then inc -> out=16'hFFFF, then 16'h0000.
//     load in=-32123 -> out=16'h8285.
//   3 Call/ret: out=5, call in=100 -> out=100, depth=1; inc -> 101; ret -> out=6, depth=0, empty=1.
//   4 Priority: ret+call+load+inc together with depth=1 (top=6) -> out=6.
//     stall=1 with call asserted -> out, depth unchanged.
//   5 Overflow: DEPTH=8; 9 nested calls in=10..18 -> out=18, full=1, ovf=1.
//     8 rets return the 8 pushed addresses in LIFO order; 9th ret -> out holds, unf=1.
//   6 Macro off: repeat test 5 -> same out/depth_cnt sequence, stack_ovf=stack_unf=0 throughout.

Source files
------------

// File: rtl/pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_call_stack
// Brief    : Parametrised program counter with an integrated return-address
//            stack. Supports stall, ret, call, load and inc, resolved in that
//            priority order on every rising clock edge.
//            Optional macro PC_STACK_ERR_EN builds the sticky overflow and
//            underflow flags; without it both flags are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module pc_call_stack #(
    parameter int               WIDTH        = 16,
    parameter int               DEPTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INC_STEP     = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         in,
    input  logic                     load,
    input  logic                     inc,
    input  logic                     stall,
    input  logic                     call,
    input  logic                     ret,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(DEPTH):0]   depth_cnt,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     stack_ovf,
    output logic                     stack_unf
);

    localparam int                 c_IDX_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_IDX_W + 1;
    localparam logic [WIDTH-1:0]   c_STEP  = WIDTH'(INC_STEP);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [WIDTH-1:0]   r_pc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_stack [DEPTH];

    logic [WIDTH-1:0]   w_pc_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic [WIDTH-1:0]   w_pc_step;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_top_idx;

    assign w_full    = (r_cnt == c_DEPTH);
    assign w_empty   = (r_cnt == '0);
    assign w_pc_step = r_pc + c_STEP;
    // Low index bits suffice: writes only happen when not full, and the top
    // index wraps correctly from DEPTH (all-zero low bits) to DEPTH-1.
    assign w_wr_idx  = r_cnt[c_IDX_W-1:0];
    assign w_top_idx = r_cnt[c_IDX_W-1:0] - c_IDX_W'(1);

    // Next PC / depth selection with stall > ret > call > load > inc priority.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_cnt_nxt = r_cnt;
        w_push    = 1'b0;
        if (stall) begin
            w_pc_nxt = r_pc;
        end else if (ret) begin
            if (!w_empty) begin
                w_pc_nxt  = r_stack[w_top_idx];
                w_cnt_nxt = r_cnt - c_ONE;
            end
        end else if (call) begin
            // The jump is taken even when the push has to be dropped.
            w_pc_nxt = in;
            if (!w_full) begin
                w_push    = 1'b1;
                w_cnt_nxt = r_cnt + c_ONE;
            end
        end else if (load) begin
            w_pc_nxt = in;
        end else if (inc) begin
            w_pc_nxt = w_pc_step;
        end
    end

    // PC and depth counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc  <= RESET_VECTOR;
            r_cnt <= '0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= w_pc_step;
        end
    end

`ifdef PC_STACK_ERR_EN
    logic r_ovf;
    logic r_unf;
    logic w_ovf_evt;
    logic w_unf_evt;

    assign w_ovf_evt = !stall && !ret && call && w_full;
    assign w_unf_evt = !stall && ret && w_empty;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_evt) r_ovf <= 1'b1;
            if (w_unf_evt) r_unf <= 1'b1;
        end
    end

    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    assign out         = r_pc;
    assign depth_cnt   = r_cnt;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_call_stack
// Brief    : Self-checking bench for pc_call_stack: directed scenarios plus
//            randomized commands checked against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_call_stack;

    localparam int               c_W     = 16;
    localparam int               c_D     = 8;
    localparam logic [c_W-1:0]   c_RV    = '0;
    localparam int               c_STEP  = 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [c_W-1:0]   in = '0;
    logic             load = 1'b0;
    logic             inc = 1'b0;
    logic             stall = 1'b0;
    logic             call = 1'b0;
    logic             ret = 1'b0;
    logic [c_W-1:0]   out;
    logic [$clog2(c_D):0] depth_cnt;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_ovf;
    logic             stack_unf;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [c_W-1:0] m_pc;
    logic [c_W-1:0] m_stk [$];
    logic           m_ovf;
    logic           m_unf;

    pc_call_stack #(
        .WIDTH(c_W), .DEPTH(c_D), .RESET_VECTOR(c_RV), .INC_STEP(c_STEP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in(in), .load(load), .inc(inc),
        .stall(stall), .call(call), .ret(ret), .out(out),
        .depth_cnt(depth_cnt), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_ovf;
        logic exp_unf;
`ifdef PC_STACK_ERR_EN
        exp_ovf = m_ovf;
        exp_unf = m_unf;
`else
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        chk({tag, ".out"},   32'(out), 32'(m_pc));
        chk({tag, ".depth"}, 32'(depth_cnt), 32'(m_stk.size()));
        chk({tag, ".full"},  32'(stack_full), 32'(m_stk.size() == c_D));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
        chk({tag, ".ovf"},   32'(stack_ovf), 32'(exp_ovf));
        chk({tag, ".unf"},   32'(stack_unf), 32'(exp_unf));
    endtask

    task automatic model_reset();
        m_pc  = c_RV;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Behavioural effect of one clock edge with the given command inputs.
    task automatic model_step(input logic [c_W-1:0] a_in, input logic a_load, input logic a_inc,
                              input logic a_stall, input logic a_call, input logic a_ret);
        if (a_stall) begin
            // nothing changes
        end else if (a_ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_unf = 1'b1;
        end else if (a_call) begin
            if (m_stk.size() < c_D) m_stk.push_back(c_W'(m_pc + c_STEP));
            else                    m_ovf = 1'b1;
            m_pc = a_in;
        end else if (a_load) begin
            m_pc = a_in;
        end else if (a_inc) begin
            m_pc = c_W'(m_pc + c_STEP);
        end
    endtask

    // Apply one command for one clock edge and check all outputs after it.
    task automatic cyc(input string tag, input logic [c_W-1:0] a_in, input logic a_load,
                       input logic a_inc, input logic a_stall, input logic a_call, input logic a_ret);
        in = a_in; load = a_load; inc = a_inc; stall = a_stall; call = a_call; ret = a_ret;
        model_step(a_in, a_load, a_inc, a_stall, a_call, a_ret);
        @(posedge clk);
        #1;
        in = '0; load = 0; inc = 0; stall = 0; call = 0; ret = 0;
        check_all(tag);
    endtask

    // Assert reset away from the clock edge and check its effect immediately.
    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [c_W-1:0] neg_val;
        model_reset();
        #2;
        check_all("rst");
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_rel");

        // Reset/inc, then asynchronous reset in the middle of a cycle
        for (int i = 0; i < 3; i++) cyc("inc", '0, 0, 1, 0, 0, 0);
        chk("inc3", 32'(out), 32'd3);
        async_reset("async_rst");

        // Load and modulo wrap, negative-looking input
        cyc("ld_ffff", 16'hFFFF, 1, 0, 0, 0, 0);
        cyc("wrap", '0, 0, 1, 0, 0, 0);
        chk("wrap0", 32'(out), 32'h0000);
        neg_val = 16'(-32123);
        cyc("ld_neg", neg_val, 1, 0, 0, 0, 0);
        chk("neg", 32'(out), 32'h8285);

        // Call / inc / ret
        cyc("ld5", 16'd5, 1, 0, 0, 0, 0);
        cyc("call100", 16'd100, 0, 0, 0, 1, 0);
        cyc("inc101", '0, 0, 1, 0, 0, 0);
        cyc("ret6", '0, 0, 0, 0, 0, 1);
        chk("ret_out6", 32'(out), 32'd6);

        // Priority: ret beats call/load/inc; stall beats everything
        cyc("ld5b", 16'd5, 1, 0, 0, 0, 0);
        cyc("call50", 16'd50, 0, 0, 0, 1, 0);
        cyc("prio_all", 16'd77, 1, 1, 0, 1, 1);
        chk("prio_out6", 32'(out), 32'd6);
        cyc("stall_call", 16'd99, 1, 1, 1, 1, 0);

        // Overflow then LIFO unwind and underflow
        async_reset("rst2");
        for (int i = 0; i < 9; i++) cyc("ncall", c_W'(10 + i), 0, 0, 0, 1, 0);
        chk("ovf_out18", 32'(out), 32'd18);
        for (int i = 0; i < 9; i++) cyc("nret", '0, 0, 0, 0, 0, 1);
        chk("unf_hold", 32'(out), 32'd1);
        cyc("stall_ret", '0, 0, 0, 1, 0, 1);

        // Randomized commands, biased toward stack traffic
        async_reset("rst3");
        for (int i = 0; i < 800; i++) begin
            cyc("rnd", c_W'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
